// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module     : store_buffer_pkg
// Description: Shared types, defaults and helpers for the store buffer.
//              Load forwarding is enabled by defining STORE_BUF_FWD_EN.
// Revision   : 1.0 - initial release
// ============================================================================
package store_buffer_pkg;

    localparam int SB_WIDTH_DEFAULT = 32;
    localparam int SB_DEPTH_DEFAULT = 4;

    // One buffered store at the default datapath width
    typedef struct packed {
        logic [SB_WIDTH_DEFAULT-1:0] addr;
        logic [SB_WIDTH_DEFAULT-1:0] data;
    } sb_entry_t;

    // Pointer width: one extra bit over the index so full and empty differ
    function automatic int sb_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : store_buffer_pkg
`default_nettype wire

// File: rtl/store_buffer_fwd_lookup.sv
`default_nettype none
// ============================================================================
// Module     : sb_fwd_lookup
// Description: Combinational youngest-first word-address match over the
//              store buffer entries. Only built when STORE_BUF_FWD_EN is
//              defined in the store_buffer top.
// Revision   : 1.0 - initial release
// ============================================================================
module sb_fwd_lookup
    import store_buffer_pkg::*;
#(
    parameter int n     = SB_WIDTH_DEFAULT,
    parameter int DEPTH = SB_DEPTH_DEFAULT,
    parameter int PW    = sb_ptr_w(SB_DEPTH_DEFAULT)
) (
    input  logic [n-3:0]   word_addr_i,
    input  logic [n-3:0]   entry_word_addr_i [DEPTH],
    input  logic [n-1:0]   entry_data_i      [DEPTH],
    input  logic [PW-1:0]  rd_ptr_i,
    input  logic [PW-1:0]  count_i,
    output logic           hit_o,
    output logic [n-1:0]   data_o
);

    logic [PW-2:0] slot;

    // Walk oldest to youngest so the youngest matching entry wins
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        slot   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_i[PW-2:0] + (PW-1)'(i);
            if ((PW'(i) < count_i) && (entry_word_addr_i[slot] == word_addr_i)) begin
                hit_o  = 1'b1;
                data_o = entry_data_i[slot];
            end
        end
    end

endmodule : sb_fwd_lookup
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module     : store_buffer
// Description: Posted-write FIFO between the cpu data port and data memory.
//              Stores are accepted in one cycle and drained oldest-first over
//              a valid/ready write channel; loads pass straight to memory.
//              Define STORE_BUF_FWD_EN to forward buffered store data to loads.
// Revision   : 1.0 - initial release
// ============================================================================
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int n     = SB_WIDTH_DEFAULT,
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [n-1:0]  aluout,
    input  logic [n-1:0]  writedata,
    output logic [n-1:0]  readdata,
    output logic [n-1:0]  mem_raddr,
    input  logic [n-1:0]  mem_rdata,
    output logic          mem_wvalid,
    output logic [n-1:0]  mem_waddr,
    output logic [n-1:0]  mem_wdata,
    input  logic          mem_wready,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int PW = sb_ptr_w(DEPTH);
    localparam int IW = PW - 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic [n-1:0]  addr_q [DEPTH];
    logic [n-1:0]  data_q [DEPTH];

    logic          deq;
    logic          enq;

    // Occupancy decode: equal pointers are empty, MSB-only difference is full
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q == {~rd_ptr_q[PW-1], rd_ptr_q[IW-1:0]});
    end

    assign mem_wvalid = ~empty;
    assign mem_waddr  = addr_q[rd_ptr_q[IW-1:0]];
    assign mem_wdata  = data_q[rd_ptr_q[IW-1:0]];
    assign mem_raddr  = aluout;
    assign overflow   = overflow_q;

    // A full buffer may still take a store when the head drains this cycle
    always_comb begin
        deq        = mem_wvalid & mem_wready;
        enq        = memwrite & (~full | deq);
        wr_ptr_d   = wr_ptr_q + PW'(enq);
        rd_ptr_d   = rd_ptr_q + PW'(deq);
        overflow_d = overflow_q | (memwrite & full & ~deq);
    end

    // Pointer and sticky-flag state; reset discards any pending stores
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage, written at the tail; cleared so the idle channel reads zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (enq) begin
            addr_q[wr_ptr_q[IW-1:0]] <= aluout;
            data_q[wr_ptr_q[IW-1:0]] <= writedata;
        end
    end

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] count;
    logic [n-3:0]  entry_word_addr [DEPTH];
    logic          fwd_hit;
    logic [n-1:0]  fwd_data;

    assign count = wr_ptr_q - rd_ptr_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_word_addr
        assign entry_word_addr[g] = addr_q[g][n-1:2];
    end

    sb_fwd_lookup #(
        .n     (n),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fwd_lookup (
        .word_addr_i       (aluout[n-1:2]),
        .entry_word_addr_i (entry_word_addr),
        .entry_data_i      (data_q),
        .rd_ptr_i          (rd_ptr_q),
        .count_i           (count),
        .hit_o             (fwd_hit),
        .data_o            (fwd_data)
    );

    // Registered entries only, so a store in the same cycle never forwards
    always_comb begin
        readdata = fwd_hit ? fwd_data : mem_rdata;
    end
`else
    // No forwarding: loads always come from memory
    always_comb begin
        readdata = mem_rdata;
    end
`endif

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module     : tb_store_buffer
// Description: Directed self-checking bench for store_buffer with a scoreboard
//              queue of expected memory writes.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int N = 32;

    typedef struct packed {
        logic [N-1:0] addr;
        logic [N-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          memwrite;
    logic [N-1:0]  aluout;
    logic [N-1:0]  writedata;
    logic [N-1:0]  readdata;
    logic [N-1:0]  mem_raddr;
    logic [N-1:0]  mem_rdata;
    logic          mem_wvalid;
    logic [N-1:0]  mem_waddr;
    logic [N-1:0]  mem_wdata;
    logic          mem_wready;
    logic          full;
    logic          empty;
    logic          overflow;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    wr_t exp_q[$];
    wr_t exp_w;

    store_buffer #(.n(N), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwrite   (memwrite),
        .aluout     (aluout),
        .writedata  (writedata),
        .readdata   (readdata),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: score any handshake seen at the negedge, return #1 after posedge
    task automatic step();
        @(negedge clk);
        if (reset && mem_wvalid && mem_wready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                chk("spurious_write", 32'(mem_wvalid), 32'h0);
            end else begin
                exp_w = exp_q.pop_front();
                chk("wr_addr", mem_waddr, exp_w.addr);
                chk("wr_data", mem_wdata, exp_w.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [N-1:0] a, input logic [N-1:0] d, input bit accepted);
        memwrite  = 1'b1;
        aluout    = a;
        writedata = d;
        if (accepted) exp_q.push_back('{addr: a, data: d});
        step();
        memwrite  = 1'b0;
    endtask

    task automatic drain();
        mem_wready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        chk("drain_done", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        reset      = 1'b0;
        memwrite   = 1'b0;
        aluout     = '0;
        writedata  = '0;
        mem_rdata  = 32'h1234_5678;
        mem_wready = 1'b0;
        @(posedge clk);
        #1;

        // 1. Reset held two cycles
        step();
        step();
        chk("rst_empty",    32'(empty),      32'h1);
        chk("rst_full",     32'(full),       32'h0);
        chk("rst_wvalid",   32'(mem_wvalid), 32'h0);
        chk("rst_overflow", 32'(overflow),   32'h0);
        chk("rst_waddr",    mem_waddr,       32'h0);
        chk("rst_wdata",    mem_wdata,       32'h0);
        reset = 1'b1;

        // 2. Single store, no combinational bypass
        mem_wready = 1'b1;
        memwrite   = 1'b1;
        aluout     = 32'h10;
        writedata  = 32'hDEAD_BEEF;
        #1;
        chk("no_bypass", 32'(mem_wvalid), 32'h0);
        exp_q.push_back('{addr: 32'h10, data: 32'hDEAD_BEEF});
        step();
        memwrite = 1'b0;
        chk("single_wvalid", 32'(mem_wvalid), 32'h1);
        chk("single_waddr",  mem_waddr,       32'h10);
        chk("single_wdata",  mem_wdata,       32'hDEAD_BEEF);
        step();
        chk("single_empty", 32'(empty), 32'h1);

        // 3. Fill, overflow, drain in order
        mem_wready = 1'b0;
        n_writes   = 0;
        for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA000_0000 + 32'(i), 1'b1);
        chk("fill_full",   32'(full),     32'h1);
        chk("fill_ovf0",   32'(overflow), 32'h0);
        chk("hold_waddr",  mem_waddr,     32'h0);
        store(32'h100, 32'hBAD0_BAD0, 1'b0);
        chk("ovf_set",     32'(overflow), 32'h1);
        chk("ovf_full",    32'(full),     32'h1);
        drain();
        step();
        chk("drain_count", 32'(n_writes), 32'h4);
        chk("drain_empty", 32'(empty),    32'h1);
        chk("ovf_sticky",  32'(overflow), 32'h1);

        // Clear overflow before the next scenario
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("ovf_cleared", 32'(overflow), 32'h0);

        // 4. Full buffer with simultaneous drain and store
        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) store(32'h30 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b1);
        chk("sim_full_pre", 32'(full), 32'h1);
        mem_wready = 1'b1;
        store(32'h40, 32'h4040_4040, 1'b1);
        chk("sim_full_post", 32'(full),     32'h1);
        chk("sim_ovf",       32'(overflow), 32'h0);
        drain();

        // 5. Load path and forwarding
        mem_wready = 1'b0;
        store(32'h20, 32'h1, 1'b1);
        store(32'h20, 32'h2, 1'b1);
        mem_rdata = 32'hAAAA_5555;
        aluout    = 32'h20;
        #1;
        chk("raddr_passthru", mem_raddr, 32'h20);
`ifdef STORE_BUF_FWD_EN
        chk("fwd_hit",  readdata, 32'h2);
`else
        chk("fwd_hit",  readdata, 32'hAAAA_5555);
`endif
        aluout = 32'h24;
        #1;
        chk("fwd_miss", readdata, 32'hAAAA_5555);
        memwrite  = 1'b1;
        aluout    = 32'h28;
        writedata = 32'h3;
        #1;
        chk("fwd_same_cycle", readdata, 32'hAAAA_5555);
        memwrite = 1'b0;
        drain();

        // 6. Reset with pending stores discards them
        mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) store(32'h50 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b1);
        reset = 1'b0;
        step();
        exp_q.delete();
        reset = 1'b1;
        chk("mid_rst_empty",  32'(empty),      32'h1);
        chk("mid_rst_wvalid", 32'(mem_wvalid), 32'h0);
        chk("mid_rst_waddr",  mem_waddr,       32'h0);
        mem_wready = 1'b1;
        n_writes   = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_wvalid", 32'(mem_wvalid), 32'h0);
        end
        chk("post_rst_writes", 32'(n_writes),     32'h0);
        chk("final_queue",     32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_store_buffer
`default_nettype wire
